iiitb_sdm: RTL and testbench
============================

IIITB_SDM -- requirements
Module: iiitb_sdm

Interface
REQ-001 The block SHALL expose parameter OVERLAP, default 1, meaning 1 = overlapping detection and 0 = non-overlapping detection.
REQ-002 The block SHALL expose parameter PATTERN, default 4'b1010, meaning the 4-bit target sequence with the MSB received first.
REQ-003 Port clk  input  1  is the single clock; all state changes SHALL occur on its rising edge.
REQ-004 Port reset  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 Port din  input  1  is the serial data bit, sampled once per rising clk edge.
REQ-006 Port y  output  1  is the detect flag, high for one cycle per completed match.
REQ-007 Positional port order SHALL be (din, reset, clk, y).

Function
REQ-008 The block SHALL be a Moore FSM; y SHALL depend only on the registered state, never combinationally on din.
REQ-009 The states SHALL be S0 (nothing matched), S1 ("1"), S2 ("10"), S3 ("101") and S4 ("1010" complete).
REQ-010 y SHALL be 1 in S4 only and 0 in every other state.
REQ-011 S0 SHALL go to S1 on din=1 and stay in S0 on din=0.
REQ-012 S1 SHALL stay in S1 on din=1 and go to S2 on din=0.
REQ-013 S2 SHALL go to S3 on din=1 and go to S0 on din=0.
REQ-014 S3 SHALL go to S1 on din=1 and go to S4 on din=0.
REQ-015 With OVERLAP=1, S4 SHALL go to S3 on din=1 and go to S0 on din=0.
REQ-016 With OVERLAP=0, S4 SHALL go to S1 on din=1 and go to S0 on din=0.
REQ-017 For a non-default PATTERN, transitions SHALL follow longest-proper-suffix-equal-to-prefix (KMP) fallback.
REQ-018 For a non-default PATTERN with OVERLAP=0, the state after the match SHALL be the one reached by the next bit from S0.
REQ-019 Latency: y SHALL rise on the same rising edge that samples the final pattern bit.
REQ-020 y SHALL fall on the following edge unless that edge completes another match.
REQ-021 With OVERLAP=1, consecutive matches SHALL be separated by at least two cycles ("101010" yields two pulses).
REQ-022 Unused encodings of the state register SHALL go to S0 on the next edge with y=0.
REQ-023 The output y SHALL be driven directly from a register or from a decode of the state register only.

Reset
REQ-024 When reset=1 at a rising clk edge, the state SHALL become S0 and y SHALL be 0, regardless of din.
REQ-025 Reset asserted mid-pattern or in S4 SHALL discard all partial-match history.
REQ-026 Detection SHALL resume with the first din sampled after reset deasserts.
REQ-027 The state register SHALL also carry an initial value of S0 so y=0 and detection works when reset is never asserted.

Verification
REQ-028 Bench setup: clk period 10 with first rising edge at t=5; reset=0 throughout; din changes on falling edges.
REQ-029 Main stream: din sampled as 0,1,0,1,0,1,0,1,1,1 at t=5..95 -> y=1 during 45-55 and 65-75, y=0 at all other times.
REQ-030 Same stream with OVERLAP=0 -> y=1 during 45-55 only.
REQ-031 Reset mid-pattern: feed 1,0,1, then assert reset for one edge, then feed 0 -> y stays 0.
REQ-032 Fallback: feed 1,1,0,1,0 -> y=1 on the fifth edge (S1 self-loop holds the prefix).
REQ-033 Quiet stream: all-zero or all-one input for 20 cycles -> y=0 for the whole run.
REQ-034 Power-up: with no reset ever applied, y SHALL be 0 (never X) from time 0.

Source files
------------

// File: rtl/iiitb_sdm.sv
// Serial "1010"-style sequence detector (Moore FSM) with a selectable
// overlap mode and a parameterised 4-bit target pattern, MSB received first.
module iiitb_sdm #(
    parameter int          OVERLAP = 1,
    parameter logic [3:0]  PATTERN = 4'b1010
) (
    input  logic din,
    input  logic reset,
    input  logic clk,
    output logic y
);

    // State value = number of pattern bits matched so far (S4 = full match).
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    // Power-up value keeps y low and detection usable without a reset.
    state_t r_state = S0;
    logic   r_y     = 1'b0;
    state_t w_next;

    // Longest prefix of PATTERN that is a suffix of (k matched bits + b).
    // For the default pattern this reduces to the hand-drawn 1010 table.
    function automatic logic [2:0] f_next(input logic [2:0] k, input logic b);
        logic [4:0] h;
        logic [4:0] m;
        logic [4:0] p;
        logic [2:0] res;
        h   = ((5'(PATTERN) >> (3'd4 - k)) << 1) | {4'b0000, b};
        res = 3'd0;
        for (int j = 1; j <= 4; j++) begin
            m = 5'((32'd1 << j) - 32'd1);
            p = 5'(PATTERN) >> (4 - j);
            if ((j <= int'(k) + 1) && ((h & m) == p)) begin
                res = 3'(j);
            end
        end
        return res;
    endfunction

    // Next-state decode; unused encodings fall back to S0.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0, S1, S2, S3: w_next = state_t'(f_next(r_state, din));
            S4:             w_next = (OVERLAP != 0) ? state_t'(f_next(3'd4, din))
                                                    : state_t'(f_next(3'd0, din));
            default:        w_next = S0;
        endcase
    end

    // State and detect flag; y is registered alongside the state it decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_y     <= (w_next == S4);
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_iiitb_sdm.sv
// Directed bench for iiitb_sdm: four instances (default overlap, default
// non-overlap, and two non-default patterns) share one stimulus stream and
// are scored against an independent last-bits model.
`timescale 1ns/1ps
module tb_iiitb_sdm;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic din   = 1'b0;
    logic y0, y1, y2, y3;
    logic [3:0] y_all;

    int checks = 0;
    int errors = 0;

    logic [3:0] pat  [4] = '{4'b1010, 4'b1010, 4'b1001, 4'b1111};
    bit         ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] hist [4] = '{4'b0, 4'b0, 4'b0, 4'b0};
    int         len  [4] = '{0, 0, 0, 0};
    logic [3:0] exp_q [$];

    assign y_all = {y3, y2, y1, y0};

    iiitb_sdm #(.OVERLAP(1), .PATTERN(4'b1010)) u0 (.din(din), .reset(reset), .clk(clk), .y(y0));
    iiitb_sdm #(.OVERLAP(0), .PATTERN(4'b1010)) u1 (.din(din), .reset(reset), .clk(clk), .y(y1));
    iiitb_sdm #(.OVERLAP(1), .PATTERN(4'b1001)) u2 (.din(din), .reset(reset), .clk(clk), .y(y2));
    iiitb_sdm #(.OVERLAP(0), .PATTERN(4'b1111)) u3 (.din(din), .reset(reset), .clk(clk), .y(y3));

    always #5 clk = ~clk;

    // Drive one bit, predict each detector's y, then check just after the edge.
    task automatic step(input logic b, input logic rst, input string tag);
        logic [3:0] e;
        logic [3:0] got;
        din   = b;
        reset = rst;
        e     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                len[i] = 0;
            end else begin
                hist[i] = {hist[i][2:0], b};
                len[i]  = len[i] + 1;
                if (len[i] >= 4 && hist[i] == pat[i]) begin
                    e[i] = 1'b1;
                    if (!ov[i]) len[i] = 0;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            assert (y_all[i] === got[i]) else begin
                errors++;
                $error("FAIL %s/u%0d: y observed %b expected %b", tag, i, y_all[i], got[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b0, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rbits;
        // Power-up: no reset ever applied before this point.
        #1;
        checks++;
        assert (y_all === 4'b0000) else begin
            errors++;
            $error("FAIL powerup: y observed %b expected %b", y_all, 4'b0000);
        end
        #0;
        // Main stream with reset low throughout: pulses at edges 45 and 65 on u0.
        feed(32'b0101010111, 10, "main");

        // Reset mid-pattern discards "101" so the trailing 0 does not match.
        feed(32'b101, 3, "mid_pre");
        step(1'b0, 1'b1, "mid_rst");
        step(1'b0, 1'b0, "mid_post");

        // Reset while in S4 discards the overlap history.
        step(1'b0, 1'b1, "s4_rst0");
        feed(32'b1010, 4, "s4_match");
        step(1'b1, 1'b1, "s4_rst");
        step(1'b0, 1'b0, "s4_post");

        // S1 self-loop keeps the leading 1 of "11010".
        step(1'b0, 1'b1, "fb_rst");
        feed(32'b11010, 5, "fallback");

        // Overlapping "101010" yields two pulses on u0, one on u1.
        step(1'b0, 1'b1, "ov_rst");
        feed(32'b101010, 6, "overlap");

        // Patterns with borders for the non-default instances.
        feed(32'b1001001, 7, "p1001");
        feed(32'b111111111, 9, "p1111");

        // Quiet streams.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "quiet0");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "quiet1");

        // Pseudo-random stream with occasional resets.
        for (int i = 0; i < 80; i++) begin
            rbits = $urandom;
            step(rbits[0], (rbits[7:3] == 5'd0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
